ball_tracker: RTL
=================

Name: ball_tracker

Overview:
- Front-end stage between the 8 raw pinball hole sensors and the scoring/LED/state logic.
- Synchronizes and debounces each sensor, detects ball arrival, and latches which hole the ball passed once per round.
- Maintains the remaining-ball count.
- Feeds getball/ball_num to the score, LED and top-level state machine, with a one-cycle hit strobe for the audio stage.

Parameters:
- DEB_CYCLES, 16, consecutive stable cycles (post-synchronizer) required to change a filtered sensor level; legal range 2..65535.
- INIT_BALLS, 8, ball count loaded in RESET state; legal range 1..15.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- ball  input  8  raw hole sensors, asynchronous, active-high, bit i = hole i
- state  input  3  game state: 0 RESET, 1 WAIT, 2 START, 3 GET, 4 OVER; others treated as WAIT
- ball_num  output  4  remaining balls
- getball  output  8  one-hot hole captured this round, 0 if none
- hit_valid  output  1  one-cycle strobe on capture
- hit_idx  output  3  index of captured hole, valid with and after hit_valid
- multi_hit  output  1  more than one hole rose in the capture cycle
- filt  output  8  debounced sensor levels, for debug LEDs

Behaviour:
- Reset (reset=1 at a clk edge) sets:
  - ball_num=INIT_BALLS; getball=0; hit_valid=0; hit_idx=0; multi_hit=0; filt=0.
  - Synchronizers and debounce counters to 0; captured flag to 0.
- Reset mid-debounce or mid-round discards all progress, with no strobe.
- Synchronizer: 2 flops per bit; output s[i].
- Debounce, per bit, 16-bit counter cnt[i]:
  - If s[i]==filt[i]: cnt[i] clears to 0.
  - Else if cnt[i]==DEB_CYCLES-1: filt[i]<=s[i] and cnt[i]<=0.
  - Else cnt[i] increments.
  - Any pulse or gap shorter than DEB_CYCLES cycles is fully rejected.
- Edge detect: rise[i] = filt[i] & ~filt_d[i], where filt_d is filt delayed one cycle. Falling edges are ignored.
- Capture is armed when state is START or GET and captured==0. On an armed cycle with any rise bit set:
  - k = lowest index with rise[k]=1.
  - getball <= one-hot(k); hit_idx <= k; hit_valid <= 1 for exactly one cycle.
  - multi_hit <= 1 if popcount(rise)>1, else 0.
  - ball_num <= ball_num-1, saturating at 0 (at 0 it stays 0 while the capture still occurs).
  - captured <= 1.
- Latency: raw bit rising at cycle 0 and held stable → filt rises at cycle DEB_CYCLES+2 → hit_valid high at cycle DEB_CYCLES+4 (one cycle for edge detect, one registered output).
- Rises in any non-armed cycle are discarded, not queued:
  - state WAIT, OVER or RESET;
  - after a capture in the same round.
- A sensor already high when START is entered does not capture; a fresh rising edge is required.
- state==WAIT: getball<=0, multi_hit<=0, captured<=0. ball_num and hit_idx hold.
- state==RESET (game state, not the reset port): ball_num<=INIT_BALLS, getball<=0, captured<=0, multi_hit<=0.
- Debouncing runs continuously in every state, so filt tracks the sensors even when capture is disarmed.
- If a capture and the state changing to WAIT coincide in the same cycle, the capture is evaluated against the current state value only.
- Outputs are fully registered; no combinational path from ball or state to any output.

Test Plan (DEB_CYCLES=4, INIT_BALLS=8):
- Reset, then state=START; ball=8'h10 held 10 cycles from cycle 0 → hit_valid=1 at cycle 8 only; getball=8'h10; hit_idx=4; ball_num=7; multi_hit=0.
- state=START; ball[2] high for 3 cycles, then 0 → no hit_valid, filt[2] stays 0, ball_num stays 8.
- state=START; ball=8'h28 rising in the same cycle → getball=8'h08, hit_idx=3, multi_hit=1, ball_num decrements by exactly 1. Then ball[0] rises while state=GET → ignored.
- Eight rounds, each START → hit on hole 1 → GET → WAIT → ball_num 7,6,…,0, and getball cleared to 0 on each WAIT. A ninth round → capture occurs with ball_num staying 0.
- ball[5] held high before START, then state=START → no capture. Drop ball[5] for 6 cycles and raise it again → capture with hit_idx=5.
- Assert reset 2 cycles into a debounce of ball[7] and during GET with getball=8'h80 → next cycle all outputs at reset values, ball_num=8, no hit_valid from the interrupted debounce.

Source files
------------

// File: rtl/ball_tracker.sv
// Front end for the pinball hole sensors: per-bit synchronize and debounce,
// then latch the first fresh ball arrival of each round and track balls left.
module ball_tracker #(
    parameter int unsigned DEB_CYCLES = 16,
    parameter int unsigned INIT_BALLS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ball,
    input  logic [2:0] state,
    output logic [3:0] ball_num,
    output logic [7:0] getball,
    output logic       hit_valid,
    output logic [2:0] hit_idx,
    output logic       multi_hit,
    output logic [7:0] filt
);

    typedef enum logic [2:0] {
        GS_RESET = 3'd0,
        GS_WAIT  = 3'd1,
        GS_START = 3'd2,
        GS_GET   = 3'd3,
        GS_OVER  = 3'd4
    } game_state_e;

    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    game_state_e gs;
    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  filt_d;
    logic [7:0]  rise;
    logic [15:0] cnt [8];
    logic        captured;
    logic [2:0]  low_idx;
    logic        many_rise;

    // Undefined state encodings behave as WAIT.
    always_comb begin
        case (state)
            3'd0:    gs = GS_RESET;
            3'd2:    gs = GS_START;
            3'd3:    gs = GS_GET;
            3'd4:    gs = GS_OVER;
            default: gs = GS_WAIT;
        endcase
    end

    always_comb begin
        low_idx = '0;
        for (int unsigned i = 8; i > 0; i--) begin
            if (rise[i-1]) low_idx = 3'(i - 1);
        end
        many_rise = (rise & (rise - 8'd1)) != 8'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= '0;
            sync2     <= '0;
            filt      <= '0;
            filt_d    <= '0;
            rise      <= '0;
            for (int unsigned i = 0; i < 8; i++) cnt[i] <= '0;
            captured  <= 1'b0;
            ball_num  <= 4'(INIT_BALLS);
            getball   <= '0;
            hit_valid <= 1'b0;
            hit_idx   <= '0;
            multi_hit <= 1'b0;
        end else begin
            sync1 <= ball;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 8; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
            filt_d    <= filt;
            // Registering the edge keeps ball/state fully decoupled from outputs.
            rise      <= filt & ~filt_d;
            hit_valid <= 1'b0;

            case (gs)
                GS_RESET: begin
                    ball_num  <= 4'(INIT_BALLS);
                    getball   <= '0;
                    captured  <= 1'b0;
                    multi_hit <= 1'b0;
                end
                GS_START, GS_GET: begin
                    if (!captured && rise != 8'd0) begin
                        getball   <= 8'd1 << low_idx;
                        hit_idx   <= low_idx;
                        hit_valid <= 1'b1;
                        multi_hit <= many_rise;
                        if (ball_num != 4'd0) ball_num <= ball_num - 4'd1;
                        captured  <= 1'b1;
                    end
                end
                GS_OVER: ;
                default: begin
                    getball   <= '0;
                    multi_hit <= 1'b0;
                    captured  <= 1'b0;
                end
            endcase
        end
    end

endmodule
